// File: rtl/sysid_qsys_ext.sv
// System-ID slave: build identity words, scratch register and 64-bit uptime with snapshot.
// Optional LED heartbeat divider enabled by defining SYSID_HEARTBEAT_EN.
module sysid_qsys_ext #(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter logic [31:0] REVISION      = 32'h0001_0000,
  parameter int          ADDR_W        = 3,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
`ifdef SYSID_HEARTBEAT_EN
  ,
  parameter int          HEARTBEAT_DIV = 50_000_000
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
`ifdef SYSID_HEARTBEAT_EN
  ,
  output logic              heartbeat
`endif
);

  logic        hit;
  logic [2:0]  word;
  logic [7:0]  sel;
  logic [31:0] scratch;
  logic [63:0] uptime;
  logic [31:0] snapshot;
  logic        freeze;
  logic        hb_en;
  logic        clr;
  logic [31:0] ctl_rd;
  logic [31:0] rd_mux;

  assign word = address[2:0];

  generate
    if (ADDR_W > 3) begin : g_hi
      assign hit = ~|address[ADDR_W-1:3];
    end else begin : g_lo
      assign hit = 1'b1;
    end
  endgenerate

  assign sel    = hit ? (8'd1 << word) : 8'd0;
  assign clr    = write & sel[6] & writedata[0];
  assign ctl_rd = {29'd0, hb_en, freeze, 1'b0};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel[0]:  rd_mux = SYSTEM_ID;
      sel[1]:  rd_mux = TIMESTAMP;
      sel[2]:  rd_mux = REVISION;
      sel[3]:  rd_mux = scratch;
      sel[4]:  rd_mux = uptime[31:0];
      sel[5]:  rd_mux = snapshot;
      sel[6]:  rd_mux = ctl_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      scratch       <= SCRATCH_RESET;
      uptime        <= '0;
      snapshot      <= '0;
      freeze        <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_mux;
        // high word captured with the low word so the pair is coherent
        if (sel[4]) snapshot <= uptime[63:32];
      end
      if (write && sel[3]) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (write && sel[6]) freeze <= writedata[1];
      if (clr) uptime <= '0;
      else if (!freeze) uptime <= uptime + 64'd1;
    end
  end

`ifdef SYSID_HEARTBEAT_EN
  localparam int HB_W = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;

  logic [HB_W-1:0] hb_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt    <= '0;
      hb_en     <= 1'b1;
      heartbeat <= 1'b0;
    end else begin
      if (write && sel[6]) hb_en <= writedata[2];
      if (hb_cnt == HB_W'(HEARTBEAT_DIV - 1)) begin
        hb_cnt <= '0;
        if (hb_en) heartbeat <= ~heartbeat;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end
`else
  assign hb_en = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_qsys_ext.sv
// Bench for sysid_qsys_ext: behavioural register-map model plus directed vectors.
// Heartbeat checks are compiled in when SYSID_HEARTBEAT_EN is defined.
module tb_sysid_qsys_ext;

  localparam logic [31:0] SID = 32'h5537_8402;
  localparam logic [31:0] TS  = 32'h6000_0000;
  localparam logic [31:0] REV = 32'h0001_0000;
  localparam logic [31:0] SR  = 32'hA5A5_0000;
  localparam int          HBD = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
`ifdef SYSID_HEARTBEAT_EN
  logic        heartbeat;
`endif

  int checks = 0;
  int errors = 0;

  sysid_qsys_ext #(
    .SYSTEM_ID(SID),
    .TIMESTAMP(TS),
    .REVISION(REV),
    .ADDR_W(4),
    .SCRATCH_RESET(SR)
`ifdef SYSID_HEARTBEAT_EN
    ,
    .HEARTBEAT_DIV(HBD)
`endif
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .byteenable(byteenable),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
`ifdef SYSID_HEARTBEAT_EN
    ,
    .heartbeat(heartbeat)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model of the register map
  logic        m_rdv;
  logic [31:0] m_rdata;
  logic [31:0] m_scr;
  logic [31:0] m_snap;
  logic [63:0] m_up;
  logic        m_frz;
  logic        m_hben;
  int          m_hbc;
  logic        m_hb;
  logic        pre_req = 1'b0;
  logic [63:0] pre_val = '0;
  logic [63:0] cur;
  logic [31:0] rv;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rdv   <= 1'b0;
      m_rdata <= '0;
      m_scr   <= SR;
      m_snap  <= '0;
      m_up    <= '0;
      m_frz   <= 1'b0;
      m_hbc   <= 0;
      m_hb    <= 1'b0;
`ifdef SYSID_HEARTBEAT_EN
      m_hben  <= 1'b1;
`else
      m_hben  <= 1'b0;
`endif
    end else begin
      cur = pre_req ? pre_val : m_up;
      case (address)
        4'd0: rv = SID;
        4'd1: rv = TS;
        4'd2: rv = REV;
        4'd3: rv = m_scr;
        4'd4: rv = cur[31:0];
        4'd5: rv = m_snap;
        4'd6: rv = {29'd0, m_hben, m_frz, 1'b0};
        default: rv = 32'd0;
      endcase
      m_rdv <= read;
      if (read) begin
        m_rdata <= rv;
        if (address == 4'd4) m_snap <= cur[63:32];
      end
      if (write && address == 4'd3) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) m_scr[8*b +: 8] <= writedata[8*b +: 8];
      end
      if (write && address == 4'd6 && writedata[0]) m_up <= 64'd0;
      else if (m_frz) m_up <= cur;
      else m_up <= cur + 64'd1;
      if (write && address == 4'd6) begin
        m_frz <= writedata[1];
`ifdef SYSID_HEARTBEAT_EN
        m_hben <= writedata[2];
`endif
      end
      if (m_hbc == HBD - 1) begin
        m_hbc <= 0;
        if (m_hben) m_hb <= ~m_hb;
      end else begin
        m_hbc <= m_hbc + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("rdv", {63'd0, readdatavalid}, {63'd0, m_rdv});
    chk("rdata", {32'd0, readdata}, {32'd0, m_rdata});
`ifdef SYSID_HEARTBEAT_EN
    chk("hb", {63'd0, heartbeat}, {63'd0, m_hb});
`endif
  end

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    address = a;
    read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    chk("rd_pulse", {63'd0, readdatavalid}, 64'd1);
    d = readdata;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    address = a;
    write = 1'b1;
    writedata = d;
    byteenable = be;
    @(negedge clock);
    write = 1'b0;
    byteenable = '0;
  endtask

  // preload the live counter for one cycle, optionally reading UPTIME_LO
  task automatic preload(input logic [63:0] v, input logic rd,
                         output logic [31:0] d);
    address = 4'd4;
    read = rd;
    pre_val = v;
    pre_req = 1'b1;
    force dut.uptime = v;
    #1 release dut.uptime;
    @(negedge clock);
    pre_req = 1'b0;
    read = 1'b0;
    d = readdata;
  endtask

  logic [31:0] d, a0, a1;
  logic [31:0] lit [3];
  int          tog;
  logic        h;

  initial begin
    lit[0] = SID;
    lit[1] = TS;
    lit[2] = REV;
    #1;
    chk("reset_rdata", {32'd0, readdata}, 64'd0);
    chk("reset_rdv", {63'd0, readdatavalid}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      do_read(4'(i), d);
      chk("id_word", {32'd0, d}, {32'd0, lit[i]});
    end
    do_read(4'd7, d);
    chk("reserved", {32'd0, d}, 64'd0);
    do_read(4'd9, d);
    chk("out_of_map", {32'd0, d}, 64'd0);
    do_read(4'd3, d);
    chk("scratch_rst", {32'd0, d}, {32'd0, SR});

    do_write(4'd3, 32'hDEAD_BEEF, 4'b1111);
    do_write(4'd3, 32'h0000_1200, 4'b0010);
    do_read(4'd3, d);
    chk("scratch_be", {32'd0, d}, 64'h0000_0000_DEAD_12EF);
    do_write(4'd0, 32'h1234_5678, 4'b1111);
    do_read(4'd0, d);
    chk("ro_write", {32'd0, d}, {32'd0, SID});

    address = 4'd3;
    read = 1'b1;
    write = 1'b1;
    writedata = 32'h0;
    byteenable = 4'b1111;
    @(negedge clock);
    read = 1'b0;
    write = 1'b0;
    byteenable = '0;
    chk("rw_same_cycle", {32'd0, readdata}, 64'h0000_0000_DEAD_12EF);
    do_read(4'd3, d);
    chk("rw_after", {32'd0, d}, 64'd0);

    preload(64'h0000_0001_FFFF_FFFE, 1'b1, d);
    chk("snap_lo", {32'd0, d}, 64'h0000_0000_FFFF_FFFE);
    repeat (4) @(negedge clock);
    do_read(4'd5, d);
    chk("snap_hi", {32'd0, d}, 64'd1);

    do_write(4'd6, 32'd2, 4'b1111);
    do_read(4'd4, a0);
    repeat (9) @(negedge clock);
    do_read(4'd4, a1);
    chk("freeze_hold", {32'd0, a1}, {32'd0, a0});
    do_read(4'd6, d);
    chk("ctl_freeze", {32'd0, d}, 64'd2);
    do_write(4'd6, 32'd1, 4'b1111);
    do_read(4'd4, d);
    chk("clear_small", {63'd0, d < 32'd5}, 64'd1);

    address = 4'd6;
    write = 1'b1;
    writedata = 32'd1;
    preload(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, d);
    write = 1'b0;
    do_read(4'd4, d);
    chk("clear_at_max", {32'd0, d}, 64'd0);
    do_read(4'd5, d);
    chk("clear_hi", {32'd0, d}, 64'd0);

    preload(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, d);
    chk("wrap_lo_max", {32'd0, d}, 64'h0000_0000_FFFF_FFFF);
    do_read(4'd5, d);
    chk("wrap_hi_max", {32'd0, d}, 64'h0000_0000_FFFF_FFFF);
    do_read(4'd4, d);
    chk("wrap_lo", {32'd0, d}, 64'd1);
    do_read(4'd5, d);
    chk("wrap_hi", {32'd0, d}, 64'd0);

    do_write(4'd6, 32'hFFFF_FFFF, 4'b0000);
    do_read(4'd6, d);
`ifdef SYSID_HEARTBEAT_EN
    chk("ctl_all", {32'd0, d}, 64'd6);
`else
    chk("ctl_all", {32'd0, d}, 64'd2);
`endif
    do_write(4'd6, 32'd0, 4'b1111);

`ifdef SYSID_HEARTBEAT_EN
    do_write(4'd6, 32'd4, 4'b1111);
    tog = 0;
    h = heartbeat;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (heartbeat != h) tog++;
      h = heartbeat;
    end
    chk("hb_toggles", 64'(tog), 64'd4);
    do_write(4'd6, 32'd0, 4'b1111);
    h = heartbeat;
    repeat (12) @(negedge clock);
    chk("hb_hold", {63'd0, heartbeat}, {63'd0, h});
    do_write(4'd6, 32'd4, 4'b1111);
    repeat (5) @(negedge clock);
`endif

    address = 4'd0;
    read = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    chk("midread_rdv", {63'd0, readdatavalid}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rdv", {63'd0, readdatavalid}, 64'd0);
    chk("async_rdata", {32'd0, readdata}, 64'd0);
`ifdef SYSID_HEARTBEAT_EN
    chk("async_hb", {63'd0, heartbeat}, 64'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    do_read(4'd3, d);
    chk("scratch_rst2", {32'd0, d}, {32'd0, SR});
    do_read(4'd6, d);
`ifdef SYSID_HEARTBEAT_EN
    chk("ctl_rst", {32'd0, d}, 64'd4);
`else
    chk("ctl_rst", {32'd0, d}, 64'd0);
`endif
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
